// File: rtl/digit_serial_adder_ctrl.sv
// digit_serial_adder_ctrl
// Adds two WIDTH-bit operands two bits per cycle through an external
// combinational 2-bit adder, LSB digit first. The carry between digits is
// kept in a register here. The result is collected in a shift register and
// published on sum/cout at the final digit.
//
// Optional build macro: DIGIT_SERIAL_OVF_EN adds a signed-overflow output (ovf).
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start; operands latched on the accepting edge
// RUN    | one digit per cycle presented to the adder (busy=1)
// DONE   | single-cycle done pulse; sum/cout valid, returns to IDLE

module digit_serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef DIGIT_SERIAL_OVF_EN
    output logic             ovf,
`endif
    output logic [1:0]       add_a,
    output logic [1:0]       add_b,
    output logic             add_cin,
    input  logic [1:0]       add_sum,
    input  logic             add_carry
);

    localparam int N     = WIDTH / 2;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_width_check
        $error("digit_serial_adder_ctrl: WIDTH must be even and >= 2");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] shift_next;
`ifdef DIGIT_SERIAL_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // Result shift register with the current adder digit entering at the top;
    // written with a shift plus part-select so WIDTH=2 needs no special case.
    always_comb begin
        shift_next = shreg_q >> 2;
        shift_next[WIDTH-1 -: 2] = add_sum;
    end

    // Next-state and datapath update for the sequencer.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef DIGIT_SERIAL_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d     = a_q >> 2;
                b_d     = b_q >> 2;
                shreg_d = shift_next;
                carry_d = add_carry;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    sum_d   = shift_next;
                    cout_d  = add_carry;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
`ifdef DIGIT_SERIAL_OVF_EN
                    // The last digit still holds the operand sign bits in bit 1.
                    ovf_d   = (a_q[1] == b_q[1]) && (add_sum[1] != a_q[1]);
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            shreg_q <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef DIGIT_SERIAL_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef DIGIT_SERIAL_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign sum     = sum_q;
    assign cout    = cout_q;
`ifdef DIGIT_SERIAL_OVF_EN
    assign ovf     = ovf_q;
`endif

    // The adder only sees live operands while digits are being processed.
    assign add_a   = busy_q ? a_q[1:0] : 2'b00;
    assign add_b   = busy_q ? b_q[1:0] : 2'b00;
    assign add_cin = busy_q ? carry_q  : 1'b0;

endmodule

// File: tb/tb_digit_serial_adder_ctrl.sv
// Bench for digit_serial_adder_ctrl (WIDTH=8) with a behavioural 2-bit adder.
module tb_digit_serial_adder_ctrl;

    localparam int W = 8;
    localparam int N = W / 2;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef DIGIT_SERIAL_OVF_EN
    logic         ovf;
`endif
    logic [1:0]   add_a;
    logic [1:0]   add_b;
    logic         add_cin;
    logic [1:0]   add_sum;
    logic         add_carry;
    logic [2:0]   add_tot;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] prev_sum;
    logic         prev_cout;

    digit_serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .cout      (cout),
`ifdef DIGIT_SERIAL_OVF_EN
        .ovf       (ovf),
`endif
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_carry (add_carry)
    );

    // Behavioural 2-bit adder stage
    assign add_tot   = {1'b0, add_a} + {1'b0, add_b} + {2'b00, add_cin};
    assign add_sum   = add_tot[1:0];
    assign add_carry = add_tot[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One complete operation starting in the next cycle (must be IDLE).
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tcin);
        logic [W:0]   total;
        logic [W:0]   part;
        logic [W-1:0] m;
        logic [W-1:0] sha;
        logic [W-1:0] shb;
        logic         exp_ci;
        total = {1'b0, ta} + {1'b0, tb_} + {{W{1'b0}}, tcin};
        @(negedge clk);
        start = 1'b1; a = ta; b = tb_; cin = tcin;
        for (int k = 1; k <= N; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            end
            m = '0;
            for (int j = 0; j < 2 * (k - 1); j++) m[j] = 1'b1;
            part   = {1'b0, ta & m} + {1'b0, tb_ & m} + {{W{1'b0}}, tcin};
            exp_ci = part[2 * (k - 1)];
            sha    = ta >> (2 * (k - 1));
            shb    = tb_ >> (2 * (k - 1));
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL run_busy c%0d: got %b expected 1", k, busy); end
            n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL run_done c%0d: got %b expected 0", k, done); end
            n_checks++; if (add_a !== sha[1:0]) begin n_fail++; $display("FAIL add_a c%0d: got %0d expected %0d", k, add_a, sha[1:0]); end
            n_checks++; if (add_b !== shb[1:0]) begin n_fail++; $display("FAIL add_b c%0d: got %0d expected %0d", k, add_b, shb[1:0]); end
            n_checks++; if (add_cin !== exp_ci) begin n_fail++; $display("FAIL add_cin c%0d: got %b expected %b", k, add_cin, exp_ci); end
            n_checks++; if (sum !== prev_sum || cout !== prev_cout) begin
                n_fail++; $display("FAIL sum_hold c%0d: got %b/%0h expected %b/%0h", k, cout, sum, prev_cout, prev_sum);
            end
        end
        @(negedge clk);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL done_pulse: got %b expected 1", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL done_busy: got %b expected 0", busy); end
        n_checks++; if (add_a !== 2'b00 || add_b !== 2'b00 || add_cin !== 1'b0) begin
            n_fail++; $display("FAIL adder_idle: got %0d/%0d/%b expected 0/0/0", add_a, add_b, add_cin);
        end
        n_checks++; if (sum !== total[W-1:0]) begin n_fail++; $display("FAIL sum %0h+%0h+%b: got %0h expected %0h", ta, tb_, tcin, sum, total[W-1:0]); end
        n_checks++; if (cout !== total[W]) begin n_fail++; $display("FAIL cout %0h+%0h+%b: got %b expected %b", ta, tb_, tcin, cout, total[W]); end
`ifdef DIGIT_SERIAL_OVF_EN
        n_checks++; if (ovf !== ((ta[W-1] == tb_[W-1]) && (total[W-1] != ta[W-1]))) begin
            n_fail++; $display("FAIL ovf %0h+%0h: got %b expected %b", ta, tb_, ovf, (ta[W-1] == tb_[W-1]) && (total[W-1] != ta[W-1]));
        end
`endif
        prev_sum  = total[W-1:0];
        prev_cout = total[W];
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_ctl: got busy=%b done=%b expected 0/0", busy, done); end
        n_checks++; if (sum !== '0 || cout !== 1'b0) begin n_fail++; $display("FAIL reset_sum: got %b/%0h expected 0/0", cout, sum); end
        n_checks++; if (add_a !== 2'b00 || add_b !== 2'b00 || add_cin !== 1'b0) begin
            n_fail++; $display("FAIL reset_adder: got %0d/%0d/%b expected 0/0/0", add_a, add_b, add_cin);
        end
`ifdef DIGIT_SERIAL_OVF_EN
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
`endif
        reset = 1'b0;
        prev_sum = '0; prev_cout = 1'b0;
        // Idle with no start must stay idle
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL idle_hold: got busy=%b done=%b expected 0/0", busy, done); end
    endtask

    task automatic test_directed();
        run_op(8'h5A, 8'h3C, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0);
        @(negedge clk);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle: got %b expected 0", done); end
    endtask

    task automatic test_back_to_back();
        run_op(8'hFF, 8'hFF, 1'b1);
        run_op(8'h00, 8'h00, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++)
            run_op(W'($urandom), W'($urandom), 1'($urandom));
    endtask

    task automatic test_start_held();
        logic [W-1:0] ha [0:23];
        logic [W-1:0] hb [0:23];
        logic         hc [0:23];
        logic         exp_done;
        logic [W:0]   tot;
        int           src;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            exp_done = (c >= N + 1) && (((c - (N + 1)) % (N + 2)) == 0);
            n_checks++; if (done !== exp_done) begin n_fail++; $display("FAIL held_done c%0d: got %b expected %b", c, done, exp_done); end
            if (exp_done) begin
                src = c - (N + 1);
                tot = {1'b0, ha[src]} + {1'b0, hb[src]} + {{W{1'b0}}, hc[src]};
                n_checks++; if (sum !== tot[W-1:0] || cout !== tot[W]) begin
                    n_fail++; $display("FAIL held_result c%0d: got %b/%0h expected %b/%0h", c, cout, sum, tot[W], tot[W-1:0]);
                end
                prev_sum = tot[W-1:0]; prev_cout = tot[W];
            end
            ha[c] = W'($urandom); hb[c] = W'($urandom); hc[c] = 1'($urandom);
            a = ha[c]; b = hb[c]; cin = hc[c];
            start = (c <= 3 * (N + 2));
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        run_op(8'hFF, 8'hFF, 1'b1);
        @(negedge clk);
        start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midrst_ctl: got busy=%b done=%b expected 0/0", busy, done); end
        n_checks++; if (sum !== '0 || cout !== 1'b0) begin n_fail++; $display("FAIL midrst_sum: got %b/%0h expected 0/0", cout, sum); end
        n_checks++; if (add_a !== 2'b00 || add_cin !== 1'b0) begin n_fail++; $display("FAIL midrst_adder: got %0d/%b expected 0/0", add_a, add_cin); end
        reset = 1'b0;
        prev_sum = '0; prev_cout = 1'b0;
        for (int i = 0; i < N + 2; i++) begin
            @(negedge clk);
            n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_quiet c%0d: got busy=%b done=%b expected 0/0", i, busy, done); end
        end
        run_op(8'hA7, 8'h3B, 1'b1);
    endtask

`ifdef DIGIT_SERIAL_OVF_EN
    task automatic test_ovf();
        run_op(8'h7F, 8'h01, 1'b0);
        run_op(8'h80, 8'hFF, 1'b0);
        run_op(8'h10, 8'h20, 1'b0);
    endtask
`endif

    initial begin
        reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        prev_sum = '0; prev_cout = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_start_held();
        test_random();
        test_reset_mid_run();
`ifdef DIGIT_SERIAL_OVF_EN
        test_ovf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/digit_serial_adder_ctrl.md
Name: digit_serial_adder_ctrl

Overview:
Sequencer that adds two WIDTH-bit operands by feeding them two bits per cycle into the team's combinational 2-bit adder stage, LSB digit first. It sits directly upstream of that adder and also collects its outputs. It latches the operands, drives the adder's a/b/cin inputs, and chains the adder's carry between digits in a register. It shifts the 2-bit sums into a result register and signals completion with a start/busy/done handshake.

Parameters:
WIDTH, 8, operand/result width in bits; must be even and >= 2 (elaboration error otherwise)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  operand A, sampled when start accepted
b  input  WIDTH  operand B, sampled when start accepted
cin  input  1  initial carry-in, sampled when start accepted
busy  output  1  high while digits are being processed (RUN)
done  output  1  one-cycle pulse: sum/cout valid
sum  output  WIDTH  result; holds until next accepted start
cout  output  1  final carry-out; holds with sum
add_a  output  2  to adder a
add_b  output  2  to adder b
add_cin  output  1  to adder cin
add_sum  input  2  from adder sum (combinational, same cycle)
add_carry  input  1  from adder carry (same cycle)

Behaviour:
- One clock domain, synchronous active-high reset; N = WIDTH/2 digits.
- States: IDLE, RUN, DONE.
- Reset (any state, incl. mid-RUN): state=IDLE; busy=0, done=0, sum=0, cout=0; operand/carry/index regs=0. An in-flight operation is aborted with no done.
- IDLE, start=1 at edge: latch a->a_reg, b->b_reg, cin->carry_reg; idx=0; go RUN. start=0: stay.
- RUN (busy=1): add_a=a_reg[1:0], add_b=b_reg[1:0], add_cin=carry_reg. At each edge:
  - a_reg, b_reg shift right by 2.
  - result reg shifts right by 2, with add_sum inserted at [WIDTH-1:WIDTH-2].
  - carry_reg<=add_carry; idx++.
  - When idx==N-1 at the edge, the final digit is captured, cout<=add_carry, and state goes to DONE.
- DONE: done=1, busy=0 for exactly one cycle; next state IDLE unconditionally.
- Latency: start accepted at edge 0; RUN occupies cycles 1..N; done high in cycle N+1.
- Next start is accepted in the IDLE cycle after DONE. Throughput is one operation per N+2 cycles.
- start in RUN/DONE is ignored, not queued. a/b/cin changes after acceptance have no effect.
- Outside RUN: add_a=0, add_b=0, add_cin=0.
- sum/cout update only at the final RUN edge. Intermediate shift contents are not visible on sum: sum is driven from a separate output register loaded at that edge.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); unsigned; no saturation.
- WIDTH=2: RUN lasts exactly one cycle.

Optional Feature:
Macro DIGIT_SERIAL_OVF_EN.
- Defined: adds output port ovf (1 bit), signed two's-complement overflow.
  - ovf = (a[WIDTH-1]==b[WIDTH-1]) && (sum[WIDTH-1]!=a[WIDTH-1]), using the operands latched at start.
  - Loaded with sum, held with it, reset to 0.
- Undefined: no ovf port, no extra registers; behaviour otherwise identical.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, cin=0, start pulse -> busy high cycles 1-4; add_a digit sequence 2,2,1,1; done in cycle 5 only; sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Carry propagates through all 4 digits (add_cin=1 in RUN cycles 2-4).
- a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1. Then a=0x00, b=0x00, cin=0 with start in the cycle after done -> accepted; sum=0x00, cout=0.
- Start held high continuously with a, b changing every cycle -> only values at accepted edges are used; ops complete every 6 cycles with correct results.
- reset asserted in RUN cycle 2 -> next cycle: IDLE, busy=0, sum=0, cout=0, no done pulse; a subsequent start works normally.
- DIGIT_SERIAL_OVF_EN defined: 0x7F+0x01 -> sum=0x80, ovf=1; 0x80+0xFF -> sum=0x7F, cout=1, ovf=1; 0x10+0x20 -> ovf=0.
